// File: rtl/cp0_defs.sv
// rtl/cp0_defs.sv - shared CP0 register numbers, exception codes and bit positions
// Purpose: constants and the exception-type decoder used by cp0_regfile and cp0_timer.
// Ports: none (package).
package cp0_defs;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // Encoded excepttype words from the exception encoder
  localparam logic [31:0] ET_INT  = 32'h0000_0001;
  localparam logic [31:0] ET_ADEL = 32'h0000_0004;
  localparam logic [31:0] ET_ADES = 32'h0000_0005;
  localparam logic [31:0] ET_SYS  = 32'h0000_0008;
  localparam logic [31:0] ET_BP   = 32'h0000_0009;
  localparam logic [31:0] ET_RI   = 32'h0000_000a;
  localparam logic [31:0] ET_OV   = 32'h0000_000c;
  localparam logic [31:0] ET_ERET = 32'h0000_000e;

  // ExcCode field values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  // Status / Cause bit positions
  localparam int STATUS_IE   = 0;
  localparam int STATUS_EXL  = 1;
  localparam int CAUSE_BD    = 31;
  localparam int IP_HI       = 15;
  localparam int IP_LO       = 8;
  localparam int EXCCODE_HI  = 6;
  localparam int EXCCODE_LO  = 2;

  // mtc0 writable bits
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } exc_t;

  // Maps an excepttype word to its ExcCode; eret and unknown codes are not
  // "valid" here (eret is handled separately by the commit logic).
  function automatic exc_t exc_decode(input logic [31:0] et);
    exc_t r;
    r = '0;
    r.valid = 1'b1;
    case (et)
      ET_INT:  r.code = EXC_INT;
      ET_ADEL: r.code = EXC_ADEL;
      ET_ADES: r.code = EXC_ADES;
      ET_SYS:  r.code = EXC_SYS;
      ET_BP:   r.code = EXC_BP;
      ET_RI:   r.code = EXC_RI;
      ET_OV:   r.code = EXC_OV;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count/Compare timer with optional divide-by-two tick
// Purpose: owns Count, Compare, the tick divider and the timer interrupt flag.
// Ports: clk, rst (sync, active-high); we_i/waddr_i/wdata_i mtc0 write port;
//        count_o, compare_o register contents; timer_int_o interrupt pending.
module cp0_timer
  import cp0_defs::*;
#(
  parameter bit CNT_DIV2 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_int;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_inc;

  assign w_wr_count   = we_i && (waddr_i == REG_COUNT);
  assign w_wr_compare = we_i && (waddr_i == REG_COMPARE);
  assign w_inc        = CNT_DIV2 ? r_tick : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick      <= 1'b0;
      r_count     <= '0;
      r_compare   <= '0;
      r_timer_int <= 1'b0;
    end else begin
      r_tick <= CNT_DIV2 ? ~r_tick : 1'b0;

      // A software write to Count replaces that cycle's increment.
      if (w_wr_count)
        r_count <= wdata_i;
      else if (w_inc)
        r_count <= r_count + 32'd1;

      // Compare write acknowledges the interrupt and beats a same-cycle match.
      if (w_wr_compare) begin
        r_compare   <= wdata_i;
        r_timer_int <= 1'b0;
      end else if ((r_compare != 32'd0) && (r_count == r_compare)) begin
        r_timer_int <= 1'b1;
      end
    end
  end

  assign count_o     = r_count;
  assign compare_o   = r_compare;
  assign timer_int_o = r_timer_int;

endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - MIPS coprocessor-0 register file with precise exception commit
// Purpose: holds Status/Cause/EPC/BadVAddr, commits exceptions, services mtc0/mfc0.
// Ports: clk, rst (sync, active-high); we_i/waddr_i/wdata_i mtc0; raddr_i/rdata_o mfc0;
//        int_i hardware interrupts; excepttype_i/pc_i/in_delayslot_i/bad_addr_i exception;
//        status_o..badvaddr_o register contents; timer_int_o timer interrupt pending.
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter bit          CNT_DIV2   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  exc_t        w_exc;
  logic        w_eret;
  logic        w_addr_exc;
  logic [31:0] w_epc_new;

  cp0_timer #(.CNT_DIV2(CNT_DIV2)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int_o)
  );

  assign w_exc      = exc_decode(excepttype_i);
  assign w_eret     = (excepttype_i == ET_ERET);
  assign w_addr_exc = (excepttype_i == ET_ADEL) || (excepttype_i == ET_ADES);
  assign w_epc_new  = in_delayslot_i ? (pc_i - 32'd4) : pc_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= STATUS_RST;
      r_cause    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      // mtc0 is applied first; exception assignments below are later
      // non-blocking writes and therefore win on the bits they touch.
      if (we_i && (waddr_i == REG_STATUS))
        r_status <= (r_status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
      if (we_i && (waddr_i == REG_CAUSE))
        r_cause <= (r_cause & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
      if (we_i && (waddr_i == REG_EPC))
        r_epc <= wdata_i;

      // IP7 folds in the timer flag, so it lags timer_int_o by one cycle.
      r_cause[IP_HI:10] <= {int_i[5] | timer_int_o, int_i[4:0]};

      if (w_exc.valid) begin
        r_status[STATUS_EXL]             <= 1'b1;
        r_cause[EXCCODE_HI:EXCCODE_LO]   <= w_exc.code;
        // Nested exceptions keep the original return point.
        if (!r_status[STATUS_EXL]) begin
          r_epc             <= w_epc_new;
          r_cause[CAUSE_BD] <= in_delayslot_i;
        end
        if (w_addr_exc)
          r_badvaddr <= bad_addr_i;
      end else if (w_eret) begin
        r_status[STATUS_EXL] <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = r_badvaddr;
      REG_COUNT:    rdata_o = count_o;
      REG_COMPARE:  rdata_o = compare_o;
      REG_STATUS:   rdata_o = r_status;
      REG_CAUSE:    rdata_o = r_cause;
      REG_EPC:      rdata_o = r_epc;
      default:      rdata_o = '0;
    endcase
  end

  assign status_o   = r_status;
  assign cause_o    = r_cause;
  assign epc_o      = r_epc;
  assign badvaddr_o = r_badvaddr;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - directed vector bench for cp0_regfile
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  int n_applied = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cp0_regfile #(.STATUS_RST(32'h0040_0000), .CNT_DIV2(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .raddr_i        (raddr_i),
    .rdata_o        (rdata_o),
    .int_i          (int_i),
    .excepttype_i   (excepttype_i),
    .pc_i           (pc_i),
    .in_delayslot_i (in_delayslot_i),
    .bad_addr_i     (bad_addr_i),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .count_o        (count_o),
    .compare_o      (compare_o),
    .badvaddr_o     (badvaddr_o),
    .timer_int_o    (timer_int_o)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  intr;
    logic [31:0] et;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] e_status;
    logic [31:0] e_cause;
    logic [31:0] e_epc;
    logic [31:0] e_badv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0; int_i = '0;
    excepttype_i = '0; pc_i = '0; in_delayslot_i = 1'b0; bad_addr_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    step();
    we_i = 1'b0;
  endtask

  initial begin
    int rise;

    //            we    waddr  wdata         raddr  int    et     pc            ds    bad           status        cause         epc           badv          rdata
    vt[0]  = '{1'b1, 5'd12, 32'hFFFFFFFF, 5'd12, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0040FF03, 32'h0,        32'h0,        32'h0,        32'h0040FF03};
    vt[1]  = '{1'b1, 5'd8,  32'h00001234, 5'd8,  6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0040FF03, 32'h0,        32'h0,        32'h0,        32'h0};
    vt[2]  = '{1'b1, 5'd12, 32'h00000000, 5'd12, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h00400000, 32'h0,        32'h0,        32'h0,        32'h00400000};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        5'd14, 6'h00, 32'h4, 32'hBFC00100, 1'b1, 32'h80000003, 32'h00400002, 32'h80000010, 32'hBFC000FC, 32'h80000003, 32'hBFC000FC};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        5'd13, 6'h00, 32'hE, 32'h0,        1'b0, 32'h0,        32'h00400000, 32'h80000010, 32'hBFC000FC, 32'h80000003, 32'h80000010};
    vt[5]  = '{1'b0, 5'd0,  32'h0,        5'd12, 6'h00, 32'h8, 32'h00001000, 1'b0, 32'h0,        32'h00400002, 32'h00000020, 32'h00001000, 32'h80000003, 32'h00400002};
    vt[6]  = '{1'b0, 5'd0,  32'h0,        5'd14, 6'h00, 32'h8, 32'h00002000, 1'b1, 32'h0,        32'h00400002, 32'h00000020, 32'h00001000, 32'h80000003, 32'h00001000};
    vt[7]  = '{1'b0, 5'd0,  32'h0,        5'd13, 6'h00, 32'hA, 32'h00003000, 1'b0, 32'h0,        32'h00400002, 32'h00000028, 32'h00001000, 32'h80000003, 32'h00000028};
    vt[8]  = '{1'b0, 5'd0,  32'h0,        5'd12, 6'h00, 32'h3, 32'h00004000, 1'b1, 32'h0,        32'h00400002, 32'h00000028, 32'h00001000, 32'h80000003, 32'h00400002};
    vt[9]  = '{1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h00400002, 32'h00000328, 32'h00001000, 32'h80000003, 32'h00000328};
    vt[10] = '{1'b0, 5'd0,  32'h0,        5'd12, 6'h00, 32'hE, 32'h0,        1'b0, 32'h0,        32'h00400000, 32'h00000328, 32'h00001000, 32'h80000003, 32'h00400000};
    vt[11] = '{1'b1, 5'd14, 32'h00000100, 5'd14, 6'h00, 32'hC, 32'h00000200, 1'b0, 32'h0,        32'h00400002, 32'h00000330, 32'h00000200, 32'h80000003, 32'h00000200};
    vt[12] = '{1'b1, 5'd12, 32'h0000FF03, 5'd12, 6'h00, 32'hE, 32'h0,        1'b0, 32'h0,        32'h0040FF01, 32'h00000330, 32'h00000200, 32'h80000003, 32'h0040FF01};
    vt[13] = '{1'b0, 5'd0,  32'h0,        5'd14, 6'h00, 32'h1, 32'h00000400, 1'b1, 32'h0,        32'h0040FF03, 32'h80000300, 32'h000003FC, 32'h80000003, 32'h000003FC};
    vt[14] = '{1'b1, 5'd14, 32'h00000055, 5'd14, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0040FF03, 32'h80000300, 32'h00000055, 32'h80000003, 32'h00000055};
    vt[15] = '{1'b0, 5'd0,  32'h0,        5'd8,  6'h00, 32'h5, 32'h00000500, 1'b0, 32'hDEADBEEF, 32'h0040FF03, 32'h80000314, 32'h00000055, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[16] = '{1'b0, 5'd0,  32'h0,        5'd13, 6'h2A, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0040FF03, 32'h8000AB14, 32'h00000055, 32'hDEADBEEF, 32'h8000AB14};
    vt[17] = '{1'b0, 5'd0,  32'h0,        5'd20, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0040FF03, 32'h80000314, 32'h00000055, 32'hDEADBEEF, 32'h0};
    vt[18] = '{1'b1, 5'd11, 32'h00000077, 5'd11, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0040FF03, 32'h80000314, 32'h00000055, 32'hDEADBEEF, 32'h00000077};

    idle();
    rst = 1'b1;
    step();
    step();
    chk("reset status", status_o, 32'h0040_0000);
    chk("reset cause", cause_o, 32'h0);
    chk("reset epc", epc_o, 32'h0);
    chk("reset badvaddr", badvaddr_o, 32'h0);
    chk("reset count", count_o, 32'h0);
    chk("reset compare", compare_o, 32'h0);
    chk("reset timer_int", {31'h0, timer_int_o}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      we_i = vt[i].we; waddr_i = vt[i].waddr; wdata_i = vt[i].wdata;
      raddr_i = vt[i].raddr; int_i = vt[i].intr; excepttype_i = vt[i].et;
      pc_i = vt[i].pc; in_delayslot_i = vt[i].ds; bad_addr_i = vt[i].bad;
      step();
      chk($sformatf("v%0d status", i), status_o, vt[i].e_status);
      chk($sformatf("v%0d cause", i), cause_o, vt[i].e_cause);
      chk($sformatf("v%0d epc", i), epc_o, vt[i].e_epc);
      chk($sformatf("v%0d badvaddr", i), badvaddr_o, vt[i].e_badv);
      chk($sformatf("v%0d rdata", i), rdata_o, vt[i].e_rdata);
    end
    idle();

    // Back-to-back Count writes span a tick cycle: written value must win.
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h1234_5678;
    step();
    chk("count write a", count_o, 32'h1234_5678);
    step();
    chk("count write b", count_o, 32'h1234_5678);
    wdata_i = 32'hFFFF_FFFF;
    step();
    chk("count write max", count_o, 32'hFFFF_FFFF);
    idle();
    step();
    step();
    chk("count wrap", count_o, 32'h0);

    // Timer match at Compare = 10 from Count = 0 with divide-by-two tick.
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    rise = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (timer_int_o) begin
        rise = n;
        break;
      end
    end
    chk("timer rise window", {31'h0, (rise >= 17 && rise <= 24)}, 32'h1);
    chk("ip7 lags at rise", {31'h0, cause_o[15]}, 32'h0);
    step();
    chk("timer held", {31'h0, timer_int_o}, 32'h1);
    chk("ip7 follows", {31'h0, cause_o[15]}, 32'h1);
    mtc0(5'd11, 32'd0);
    chk("compare write clears", {31'h0, timer_int_o}, 32'h0);
    chk("ip7 still lagging", {31'h0, cause_o[15]}, 32'h1);
    step();
    chk("ip7 cleared", {31'h0, cause_o[15]}, 32'h0);

    // Compare write in the match cycle: clear wins.
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd10);
    mtc0(5'd11, 32'd10);
    chk("clear beats match", {31'h0, timer_int_o}, 32'h0);

    // Reset mid-operation overrides mtc0 and exception in the same cycle.
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF;
    excepttype_i = 32'h4; pc_i = 32'h1000; bad_addr_i = 32'h55; int_i = 6'h3F;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("midrst status", status_o, 32'h0040_0000);
    chk("midrst cause", cause_o, 32'h0);
    chk("midrst epc", epc_o, 32'h0);
    chk("midrst badvaddr", badvaddr_o, 32'h0);
    chk("midrst count", count_o, 32'h0);
    chk("midrst compare", compare_o, 32'h0);
    chk("midrst timer_int", {31'h0, timer_int_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
